// File: rtl/bnn_infer_ctrl.sv
// Sequencer for the combinational BNN classifier core: assembles an 8x8 image row by row,
// holds it while the core settles, captures the class scores and returns the argmax.
module bnn_infer_ctrl #(
    parameter int unsigned NUM_ROWS      = 8,
    parameter int unsigned ROW_W         = 8,
    parameter int unsigned NUM_CLASSES   = 10,
    parameter int unsigned SCORE_W       = 5,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           row_valid_i,
    output logic                           row_ready_o,
    input  logic [ROW_W-1:0]               row_data_i,
    output logic [NUM_ROWS*ROW_W-1:0]      image_o,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_i,
    output logic                           result_valid_o,
    input  logic                           result_ready_i,
    output logic [3:0]                     class_o,
    output logic [SCORE_W-1:0]             score_o,
    output logic                           busy_o
);

    localparam int unsigned IMG_W     = NUM_ROWS * ROW_W;
    localparam int unsigned SC_W      = NUM_CLASSES * SCORE_W;
    localparam int unsigned ROW_CNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned IDX_W     = $clog2(NUM_CLASSES + 1);
    localparam int unsigned SETTLE_W  = 4;
    localparam int unsigned CLASS_W   = 4;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_ARGMAX  = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IMG_W-1:0]     image_q, image_d;
    logic [SC_W-1:0]      score_reg_q, score_reg_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic [CLASS_W-1:0]   class_q, class_d;
    logic [SCORE_W-1:0]   score_out_q, score_out_d;
    logic                 row_ready_q, row_ready_d;
    logic                 busy_q, busy_d;
    logic                 result_valid_q, result_valid_d;

    logic                 row_accept;
    logic [SC_W-1:0]      score_shift;
    logic [SCORE_W-1:0]   cur_score;

    // A row that coincides with clear_i is dropped.
    assign row_accept  = (state_q == S_LOAD) && row_valid_i && !clear_i;
    assign score_shift = score_reg_q >> (32'(idx_q) * SCORE_W);
    assign cur_score   = score_shift[SCORE_W-1:0];

    always_comb begin
        state_d        = state_q;
        row_cnt_d      = row_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        idx_d          = idx_q;
        image_d        = image_q;
        score_reg_d    = score_reg_q;
        best_score_d   = best_score_q;
        best_idx_d     = best_idx_q;
        class_d        = class_q;
        score_out_d    = score_out_q;

        unique case (state_q)
            S_LOAD: begin
                if (row_accept) begin
                    // The k-th row lands in image row NUM_ROWS-1-k (first row at the MSBs).
                    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                        if (row_cnt_q == ROW_CNT_W'(NUM_ROWS - 1 - r)) begin
                            image_d[r*ROW_W +: ROW_W] = row_data_i;
                        end
                    end
                    if (row_cnt_q == ROW_CNT_W'(NUM_ROWS - 1)) begin
                        state_d      = S_SETTLE;
                        row_cnt_d    = '0;
                        settle_cnt_d = SETTLE_W'(SETTLE_CYCLES);
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q <= SETTLE_W'(1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                score_reg_d = scores_i;
                idx_d       = '0;
                state_d     = S_ARGMAX;
            end
            S_ARGMAX: begin
                // One lane per cycle, then a commit cycle that publishes the winner.
                if (idx_q == IDX_W'(NUM_CLASSES)) begin
                    class_d     = CLASS_W'(best_idx_q);
                    score_out_d = best_score_q;
                    state_d     = S_DONE;
                end else begin
                    if ((idx_q == '0) || ($signed(cur_score) > $signed(best_score_q))) begin
                        best_score_d = cur_score;
                        best_idx_d   = idx_q;
                    end
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (result_ready_i) begin
                    state_d   = S_LOAD;
                    row_cnt_d = '0;
                end
            end
            default: begin
                state_d   = S_LOAD;
                row_cnt_d = '0;
            end
        endcase

        if (clear_i) begin
            state_d   = S_LOAD;
            row_cnt_d = '0;
        end

        row_ready_d    = (state_d == S_LOAD);
        busy_d         = (state_d != S_LOAD);
        result_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_LOAD;
            row_cnt_q      <= '0;
            settle_cnt_q   <= '0;
            idx_q          <= '0;
            image_q        <= '0;
            score_reg_q    <= '0;
            best_score_q   <= '0;
            best_idx_q     <= '0;
            class_q        <= '0;
            score_out_q    <= '0;
            row_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_cnt_q      <= row_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            idx_q          <= idx_d;
            image_q        <= image_d;
            score_reg_q    <= score_reg_d;
            best_score_q   <= best_score_d;
            best_idx_q     <= best_idx_d;
            class_q        <= class_d;
            score_out_q    <= score_out_d;
            row_ready_q    <= row_ready_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign row_ready_o    = row_ready_q;
    assign busy_o         = busy_q;
    assign result_valid_o = result_valid_q;
    assign image_o        = image_q;
    assign class_o        = class_q;
    assign score_o        = score_out_q;

endmodule

// File: tb/tb_bnn_infer_ctrl.sv
// Scoreboard bench for bnn_infer_ctrl: the bench plays the classifier core and predicts each argmax.
module tb_bnn_infer_ctrl;

    localparam int unsigned NUM_ROWS      = 8;
    localparam int unsigned ROW_W         = 8;
    localparam int unsigned NUM_CLASSES   = 10;
    localparam int unsigned SCORE_W       = 5;
    localparam int unsigned SETTLE_CYCLES = 2;
    localparam int          LAT           = SETTLE_CYCLES + NUM_CLASSES + 2;

    typedef struct packed {
        logic [3:0]         cls;
        logic [SCORE_W-1:0] sc;
    } exp_t;

    logic                           clk_i = 1'b0;
    logic                           rst_ni = 1'b0;
    logic                           clear_i = 1'b0;
    logic                           row_valid_i = 1'b0;
    logic                           row_ready_o;
    logic [ROW_W-1:0]               row_data_i = '0;
    logic [NUM_ROWS*ROW_W-1:0]      image_o;
    logic [NUM_CLASSES*SCORE_W-1:0] scores_i = '0;
    logic                           result_valid_o;
    logic                           result_ready_i = 1'b0;
    logic [3:0]                     class_o;
    logic [SCORE_W-1:0]             score_o;
    logic                           busy_o;

    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    exp_t sb_q[$];
    logic [63:0] cur_img = '0;

    bnn_infer_ctrl #(
        .NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W), .NUM_CLASSES(NUM_CLASSES),
        .SCORE_W(SCORE_W), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .row_valid_i(row_valid_i), .row_ready_o(row_ready_o), .row_data_i(row_data_i),
        .image_o(image_o), .scores_i(scores_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .class_o(class_o), .score_o(score_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Reference argmax: find the maximum value first, then the lowest lane holding it.
    function automatic exp_t ref_argmax(input logic [NUM_CLASSES*SCORE_W-1:0] s);
        logic signed [SCORE_W-1:0] mx;
        logic signed [SCORE_W-1:0] v;
        exp_t r;
        mx = 5'b10000;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            v = s[i*SCORE_W +: SCORE_W];
            if (v > mx) mx = v;
        end
        r.cls = '0;
        r.sc  = mx;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            v = s[i*SCORE_W +: SCORE_W];
            if (v == mx) r.cls = 4'(i);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_all(input logic [SCORE_W-1:0] v);
        for (int i = 0; i < NUM_CLASSES; i++) scores_i[i*SCORE_W +: SCORE_W] = v;
    endtask

    task automatic set_random_scores();
        for (int i = 0; i < NUM_CLASSES; i++) scores_i[i*SCORE_W +: SCORE_W] = SCORE_W'($urandom);
    endtask

    task automatic send_row(input logic [7:0] d, input int k, output int acc);
        logic rdy;
        row_valid_i = 1'b1;
        row_data_i  = d;
        acc = -1;
        for (int t = 0; t < 64; t++) begin
            rdy = row_ready_o;
            step();
            if (rdy) begin
                acc = edge_cnt;
                cur_img[(7-k)*8 +: 8] = d;
                break;
            end
        end
        row_valid_i = 1'b0;
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL row_accept: row %0d not accepted within 64 cycles", k);
        end
    endtask

    task automatic wait_result(input int acc, output int lat);
        lat = -1;
        for (int t = 0; t < 200; t++) begin
            if (result_valid_o) begin
                lat = edge_cnt - acc;
                break;
            end
            step();
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL result_wait: result_valid_o not seen within 200 cycles");
        end
    endtask

    task automatic do_image(input logic [63:0] img, input int gap, output int lat);
        int acc;
        for (int k = 0; k < 8; k++) begin
            send_row(img[(7-k)*8 +: 8], k, acc);
            if (k < 7) repeat (gap) step();
        end
        wait_result(acc, lat);
    endtask

    task automatic consume();
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) step();
        checks++;
        if ({row_ready_o, busy_o, result_valid_o, class_o, score_o} !== {3'b100, 4'd0, 5'd0}) begin
            failures++;
            $display("FAIL reset_ctrl: rdy/busy/vld/cls/sc got %b %b %b %0d %0d want 1 0 0 0 0",
                     row_ready_o, busy_o, result_valid_o, class_o, score_o);
        end
        checks++;
        if (image_o !== 64'h0) begin
            failures++;
            $display("FAIL reset_image: got %h want 0", image_o);
        end
        rst_ni = 1'b1;
        step();
        checks++;
        if ({row_ready_o, busy_o, result_valid_o} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release: rdy/busy/vld got %b%b%b want 100", row_ready_o, busy_o, result_valid_o);
        end
    endtask

    task automatic test_single_image();
        int lat;
        exp_t e;
        set_all(5'b11110);
        scores_i[3*SCORE_W +: SCORE_W] = 5'd7;
        sb_q.push_back(ref_argmax(scores_i));
        do_image(64'h0000442C3C040400, 0, lat);
        checks++;
        if (image_o !== 64'h0000442C3C040400) begin
            failures++;
            $display("FAIL single_image: image_o got %h want 0000442c3c040400", image_o);
        end
        checks++;
        if (lat != LAT) begin
            failures++;
            $display("FAIL single_latency: got %0d want %0d", lat, LAT);
        end
        e = sb_q.pop_front();
        checks++;
        if ({class_o, score_o} !== {e.cls, e.sc} || e.cls !== 4'd3) begin
            failures++;
            $display("FAIL single_result: class/score got %0d %0d want 3 7", class_o, $signed(score_o));
        end
        consume();
        checks++;
        if ({row_ready_o, result_valid_o, busy_o} !== 3'b100) begin
            failures++;
            $display("FAIL single_handoff: rdy/vld/busy got %b%b%b want 100", row_ready_o, result_valid_o, busy_o);
        end
    endtask

    task automatic test_tie_negatives();
        int lat;
        exp_t e;
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: begin
                    set_all(5'b11111);
                    scores_i[2*SCORE_W +: SCORE_W] = 5'd5;
                    scores_i[6*SCORE_W +: SCORE_W] = 5'd5;
                end
                1: begin
                    set_all(5'b10000);
                    scores_i[9*SCORE_W +: SCORE_W] = 5'b10001;
                end
                default: set_all(5'b10000);
            endcase
            sb_q.push_back(ref_argmax(scores_i));
            do_image({$urandom, $urandom}, 0, lat);
            e = sb_q.pop_front();
            checks++;
            if ({class_o, score_o} !== {e.cls, e.sc}) begin
                failures++;
                $display("FAIL tie_neg_%0d: class/score got %0d %0d want %0d %0d",
                         s, class_o, $signed(score_o), e.cls, $signed(e.sc));
            end
            checks++;
            if (lat != LAT) begin
                failures++;
                $display("FAIL tie_neg_latency_%0d: got %0d want %0d", s, lat, LAT);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        set_random_scores();
        sb_q.push_back(ref_argmax(scores_i));
        do_image({$urandom, $urandom}, 0, lat);
        e = sb_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({result_valid_o, row_ready_o, class_o, score_o} !== {1'b1, 1'b0, e.cls, e.sc}) begin
                failures++;
                $display("FAIL backpressure_hold_%0d: vld/rdy/cls/sc got %b %b %0d %0d want 1 0 %0d %0d",
                         c, result_valid_o, row_ready_o, class_o, $signed(score_o), e.cls, $signed(e.sc));
            end
            set_random_scores();
            step();
        end
        consume();
        checks++;
        if ({row_ready_o, result_valid_o, busy_o, class_o, score_o} !== {3'b100, e.cls, e.sc}) begin
            failures++;
            $display("FAIL backpressure_release: rdy/vld/busy/cls/sc got %b%b%b %0d %0d want 100 %0d %0d",
                     row_ready_o, result_valid_o, busy_o, class_o, $signed(score_o), e.cls, $signed(e.sc));
        end
    endtask

    task automatic test_input_stalls();
        int acc;
        int lat;
        exp_t e;
        logic [63:0] img;
        img = {$urandom, $urandom};
        set_random_scores();
        sb_q.push_back(ref_argmax(scores_i));
        for (int k = 0; k < 8; k++) begin
            send_row(img[(7-k)*8 +: 8], k, acc);
            if (k < 7) begin
                for (int g = 0; g < 3; g++) begin
                    step();
                    if (k == 3) begin
                        checks++;
                        if ({image_o, row_ready_o, busy_o} !== {cur_img, 2'b10}) begin
                            failures++;
                            $display("FAIL stall_gap_%0d: image/rdy/busy got %h %b%b want %h 10",
                                     g, image_o, row_ready_o, busy_o, cur_img);
                        end
                    end
                end
            end
        end
        wait_result(acc, lat);
        checks++;
        if (lat != LAT || image_o !== img) begin
            failures++;
            $display("FAIL stall_latency: lat %0d image %h want %0d %h", lat, image_o, LAT, img);
        end
        e = sb_q.pop_front();
        checks++;
        if ({class_o, score_o} !== {e.cls, e.sc}) begin
            failures++;
            $display("FAIL stall_result: got %0d %0d want %0d %0d", class_o, $signed(score_o), e.cls, $signed(e.sc));
        end
        consume();
    endtask

    task automatic test_abort_clear();
        int acc;
        int lat;
        exp_t e;
        logic [63:0] img_a;
        logic [63:0] img_b;
        img_a = {$urandom, $urandom};
        img_b = {$urandom, $urandom};
        for (int k = 0; k < 4; k++) send_row(img_a[(7-k)*8 +: 8], k, acc);
        clear_i     = 1'b1;
        row_valid_i = 1'b1;
        row_data_i  = 8'hEE;
        step();
        clear_i     = 1'b0;
        row_valid_i = 1'b0;
        checks++;
        if ({image_o, row_ready_o, busy_o} !== {cur_img, 2'b10}) begin
            failures++;
            $display("FAIL clear_discard: image/rdy/busy got %h %b%b want %h 10", image_o, row_ready_o, busy_o, cur_img);
        end
        set_random_scores();
        sb_q.push_back(ref_argmax(scores_i));
        for (int k = 0; k < 8; k++) begin
            send_row(img_b[(7-k)*8 +: 8], k, acc);
            if (k == 0 || k == 6) begin
                checks++;
                if ({image_o, row_ready_o, busy_o} !== {cur_img, 2'b10}) begin
                    failures++;
                    $display("FAIL clear_reload_%0d: image/rdy/busy got %h %b%b want %h 10",
                             k, image_o, row_ready_o, busy_o, cur_img);
                end
            end
        end
        checks++;
        if ({image_o, busy_o} !== {img_b, 1'b1}) begin
            failures++;
            $display("FAIL clear_full: image/busy got %h %b want %h 1", image_o, busy_o, img_b);
        end
        wait_result(acc, lat);
        e = sb_q.pop_front();
        checks++;
        if (lat != LAT || {class_o, score_o} !== {e.cls, e.sc}) begin
            failures++;
            $display("FAIL clear_result: lat %0d cls %0d sc %0d want %0d %0d %0d",
                     lat, class_o, $signed(score_o), LAT, e.cls, $signed(e.sc));
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checks++;
        if ({result_valid_o, row_ready_o, class_o, score_o} !== {2'b01, e.cls, e.sc}) begin
            failures++;
            $display("FAIL clear_in_done: vld/rdy/cls/sc got %b%b %0d %0d want 01 %0d %0d",
                     result_valid_o, row_ready_o, class_o, $signed(score_o), e.cls, $signed(e.sc));
        end
    endtask

    task automatic test_abort_reset();
        int acc;
        bit saw_valid;
        set_all(5'd9);
        for (int k = 0; k < 8; k++) send_row(8'(8'h10 + k), k, acc);
        repeat (SETTLE_CYCLES + 1 + 4) step();
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({row_ready_o, busy_o, result_valid_o, class_o, score_o, image_o} !== {3'b100, 4'd0, 5'd0, 64'h0}) begin
            failures++;
            $display("FAIL reset_mid_argmax: rdy/busy/vld/cls/sc/img got %b%b%b %0d %0d %h want 100 0 0 0",
                     row_ready_o, busy_o, result_valid_o, class_o, score_o, image_o);
        end
        cur_img = '0;
        repeat (2) step();
        rst_ni = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            saw_valid |= result_valid_o;
        end
        checks++;
        if ({saw_valid, row_ready_o, busy_o} !== 3'b010) begin
            failures++;
            $display("FAIL reset_no_result: saw_valid/rdy/busy got %b%b%b want 010", saw_valid, row_ready_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        exp_t e;
        result_ready_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            set_random_scores();
            sb_q.push_back(ref_argmax(scores_i));
            do_image({$urandom, $urandom}, n % 2, lat);
            e = sb_q.pop_front();
            checks++;
            if (lat != LAT || {class_o, score_o} !== {e.cls, e.sc}) begin
                failures++;
                $display("FAIL b2b_%0d: lat %0d cls %0d sc %0d want %0d %0d %0d",
                         n, lat, class_o, $signed(score_o), LAT, e.cls, $signed(e.sc));
            end
            step();
            checks++;
            if ({result_valid_o, row_ready_o} !== 2'b01) begin
                failures++;
                $display("FAIL b2b_handoff_%0d: vld/rdy got %b%b want 01", n, result_valid_o, row_ready_o);
            end
        end
        result_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_image();
        test_tie_negatives();
        test_backpressure();
        test_input_stalls();
        test_abort_clear();
        test_abort_reset();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
